// File: rtl/fft_bfly_addr_seq.sv
// fft_bfly_addr_seq: butterfly address / stage / twiddle sequencer for a
// 32-point in-place radix-2 FFT. Walks 5 stages x 16 butterflies and
// inserts GAP_CYCLES idle cycles between stages for write-back drain.
// Optional feature macro: FFT_SEQ_STALL_CNT_EN adds a saturating stall_cnt
// output counting valid && !ready cycles.
module fft_bfly_addr_seq #(
    parameter int GAP_CYCLES = 2,
    parameter int STALL_W    = 16
) (
    input  logic               clk,
    input  logic               clr,
    input  logic               start,
    input  logic               abort,
    input  logic               ready,
    output logic               valid,
    output logic [4:0]         d_even,
    output logic [4:0]         d_odd,
    output logic [2:0]         s,
    output logic [3:0]         tw,
    output logic               busy,
    output logic               done
`ifdef FFT_SEQ_STALL_CNT_EN
    ,
    output logic [STALL_W-1:0] stall_cnt
`endif
);

    typedef enum logic [1:0] {IDLE, RUN, GAP, DONE} state_t;

    // last gap_cnt value before returning to RUN (unused when GAP_CYCLES=0)
    localparam logic [3:0] GAP_LAST = 4'(GAP_CYCLES - 1);

    // elaboration-time guard: an illegal configuration leaves a named marker block
    if (GAP_CYCLES < 0 || GAP_CYCLES > 15 || STALL_W < 1) begin : g_illegal_params
    end

    state_t      state_q, state_d;
    logic [3:0]  j_q, j_d;
    logic [2:0]  s_q, s_d;
    logic [3:0]  gap_cnt_q, gap_cnt_d;
    logic        valid_q, valid_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [3:0]  tw_q, tw_d;

    // next-state: abort overrides everything except clr; start only from IDLE
    always_comb begin
        state_d   = state_q;
        j_d       = j_q;
        s_d       = s_q;
        gap_cnt_d = gap_cnt_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    j_d     = 4'd0;
                    s_d     = 3'd0;
                end
            end
            RUN: begin
                if (ready) begin
                    if (j_q != 4'd15) begin
                        j_d = j_q + 4'd1;
                    end else if (s_q != 3'd4) begin
                        j_d = 4'd0;
                        s_d = s_q + 3'd1;
                        if (GAP_CYCLES > 0) begin
                            state_d   = GAP;
                            gap_cnt_d = 4'd0;
                        end
                    end else begin
                        state_d = DONE;
                        j_d     = 4'd0;
                        s_d     = 3'd0;
                    end
                end
            end
            GAP: begin
                gap_cnt_d = gap_cnt_q + 4'd1;
                if (gap_cnt_q == GAP_LAST) state_d = RUN;
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (abort) begin
            state_d   = IDLE;
            j_d       = 4'd0;
            s_d       = 3'd0;
            gap_cnt_d = 4'd0;
        end
    end

    // registered status and twiddle, derived from the next state/counters
    always_comb begin
        valid_d = (state_d == RUN);
        busy_d  = (state_d == RUN) || (state_d == GAP);
        done_d  = (state_d == DONE);
        // tw = (j & ((1<<s)-1)) << (4-s), truncated to 4 bits
        case (s_d)
            3'd1:    tw_d = {j_d[0],   3'b000};
            3'd2:    tw_d = {j_d[1:0], 2'b00};
            3'd3:    tw_d = {j_d[2:0], 1'b0};
            3'd4:    tw_d = j_d;
            default: tw_d = 4'd0;
        endcase
    end

    // state and output registers
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q   <= IDLE;
            j_q       <= 4'd0;
            s_q       <= 3'd0;
            gap_cnt_q <= 4'd0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            tw_q      <= 4'd0;
        end else begin
            state_q   <= state_d;
            j_q       <= j_d;
            s_q       <= s_d;
            gap_cnt_q <= gap_cnt_d;
            valid_q   <= valid_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            tw_q      <= tw_d;
        end
    end

    assign valid  = valid_q;
    assign busy   = busy_q;
    assign done   = done_q;
    assign s      = s_q;
    assign tw     = tw_q;
    assign d_even = {j_q, 1'b0};
    assign d_odd  = {j_q, 1'b1};

`ifdef FFT_SEQ_STALL_CNT_EN
    logic [STALL_W-1:0] stall_cnt_q, stall_cnt_d;

    // stall counter: restarts with an accepted start, saturates, holds otherwise
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (state_q == IDLE && start && !abort)
            stall_cnt_d = '0;
        else if (valid_q && !ready && stall_cnt_q != '1)
            stall_cnt_d = stall_cnt_q + 1'b1;
    end

    // stall counter register
    always_ff @(posedge clk) begin
        if (clr) stall_cnt_q <= '0;
        else     stall_cnt_q <= stall_cnt_d;
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fft_bfly_addr_seq.sv
// Directed self-checking bench for fft_bfly_addr_seq (GAP_CYCLES=2 and 0).
module tb_fft_bfly_addr_seq;

    logic       clk = 1'b0;
    logic       clr, start, abort, ready;
    logic       valid, busy, done;
    logic [4:0] d_even, d_odd;
    logic [2:0] s;
    logic [3:0] tw;
    logic       start2, ready2;
    logic       valid2, busy2, done2;
    logic [4:0] d_even2, d_odd2;
    logic [2:0] s2;
    logic [3:0] tw2;
`ifdef FFT_SEQ_STALL_CNT_EN
    logic [15:0] stall_cnt, stall_cnt2;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    fft_bfly_addr_seq #(.GAP_CYCLES(2), .STALL_W(16)) dut (
        .clk(clk), .clr(clr), .start(start), .abort(abort), .ready(ready),
        .valid(valid), .d_even(d_even), .d_odd(d_odd), .s(s), .tw(tw),
        .busy(busy), .done(done)
`ifdef FFT_SEQ_STALL_CNT_EN
        , .stall_cnt(stall_cnt)
`endif
    );

    fft_bfly_addr_seq #(.GAP_CYCLES(0), .STALL_W(16)) dut0 (
        .clk(clk), .clr(clr), .start(start2), .abort(1'b0), .ready(ready2),
        .valid(valid2), .d_even(d_even2), .d_odd(d_odd2), .s(s2), .tw(tw2),
        .busy(busy2), .done(done2)
`ifdef FFT_SEQ_STALL_CNT_EN
        , .stall_cnt(stall_cnt2)
`endif
    );

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // one clock; sample point is 1 time unit after the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // one full pass on dut; ready dropped for k in [stall_k, stall_k+2],
    // extra start pulsed in cycle start_k. Cycle 1 = first cycle after start.
    task automatic pass(input int stall_k, input int start_k,
                        output int xfers, output int dcnt, output int dcyc);
        xfers = 0; dcnt = 0; dcyc = -1;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 1; k <= 100; k++) begin
            ready = !(stall_k > 0 && k >= stall_k && k <= stall_k + 2);
            start = (k == start_k);
            if (valid && ready) xfers++;
            if (done) begin dcnt++; dcyc = k; end
            if (stall_k == 0 && start_k == 0) begin
                if (k == 1)  begin chk("c1_valid", valid, 1); chk("c1_s", s, 0); end
                if (k == 6)  begin chk("j5_even", d_even, 10); chk("j5_odd", d_odd, 11);
                                   chk("j5_tw", tw, 0); end
                if (k == 16) chk("c16_valid", valid, 1);
                if (k == 17) begin chk("c17_valid", valid, 0); chk("c17_busy", busy, 1); end
                if (k == 18) chk("c18_valid", valid, 0);
                if (k == 19) begin chk("c19_valid", valid, 1); chk("c19_s", s, 1);
                                   chk("c19_even", d_even, 0); end
                if (k == 44) begin chk("s2j7_s", s, 2); chk("s2j7_tw", tw, 12); end
                if (k == 70) begin chk("s3j15_even", d_even, 30); chk("s3j15_tw", tw, 14); end
                if (k == 82) begin chk("s4j9_s", s, 4); chk("s4j9_tw", tw, 9); end
                if (k == 88) chk("c88_valid", valid, 1);
            end
            if (stall_k > 0 && k >= stall_k && k <= stall_k + 3) begin
                chk("frz_valid", valid, 1);
                chk("frz_even", d_even, 8);
                chk("frz_s", s, 1);
            end
            if (stall_k > 0 && k == stall_k + 4) chk("resume_even", d_even, 10);
            tick();
        end
        ready = 1'b1;
        start = 1'b0;
    endtask

    int xf, dc, dy;

    initial begin
        clr = 1'b1; start = 1'b0; abort = 1'b0; ready = 1'b1;
        start2 = 1'b0; ready2 = 1'b1;
        tick(); tick();
        clr = 1'b0;
        chk("rst_valid", valid, 0); chk("rst_busy", busy, 0); chk("rst_done", done, 0);
        chk("rst_even", d_even, 0); chk("rst_odd", d_odd, 1); chk("rst_tw", tw, 0);
        chk("rst_s", s, 0);

        // full pass, ready held high
        pass(0, 0, xf, dc, dy);
        chk("p1_xfers", xf, 80); chk("p1_dcnt", dc, 1); chk("p1_dcyc", dy, 89);
`ifdef FFT_SEQ_STALL_CNT_EN
        chk("p1_stall", stall_cnt, 0);
`endif

        // backpressure at s=1, j=4 (cycle 23)
        pass(23, 0, xf, dc, dy);
        chk("bp_xfers", xf, 80); chk("bp_dcnt", dc, 1); chk("bp_dcyc", dy, 92);
`ifdef FFT_SEQ_STALL_CNT_EN
        chk("bp_stall", stall_cnt, 3);
`endif

        // abort at s=2, j=6 (cycle 43)
        start = 1'b1; tick(); start = 1'b0;
        for (int k = 1; k < 43; k++) tick();
        chk("ab_pre_s", s, 2); chk("ab_pre_even", d_even, 12);
        abort = 1'b1; tick(); abort = 1'b0;
        chk("ab_valid", valid, 0); chk("ab_busy", busy, 0); chk("ab_s", s, 0);
        chk("ab_even", d_even, 0);
        dc = 0;
        for (int k = 0; k < 6; k++) begin if (done) dc++; tick(); end
        chk("ab_nodone", dc, 0);
        start = 1'b1; tick(); start = 1'b0;
        chk("ab_re_valid", valid, 1); chk("ab_re_s", s, 0); chk("ab_re_even", d_even, 0);
        tick();
        chk("ab_re_j1", d_even, 2);

        // clr mid-GAP (restart pass then clear in cycle 17)
        clr = 1'b1; tick(); clr = 1'b0;
        start = 1'b1; tick(); start = 1'b0;
        for (int k = 1; k < 17; k++) tick();
        chk("gap_busy", busy, 1); chk("gap_valid", valid, 0);
        clr = 1'b1; tick(); clr = 1'b0;
        chk("clr_valid", valid, 0); chk("clr_busy", busy, 0); chk("clr_s", s, 0);
        chk("clr_even", d_even, 0); chk("clr_odd", d_odd, 1); chk("clr_tw", tw, 0);
        tick();
        chk("clr_idle", valid, 0);

        // start pulsed during RUN is ignored
        pass(0, 5, xf, dc, dy);
        chk("sr_xfers", xf, 80); chk("sr_dcnt", dc, 1); chk("sr_dcyc", dy, 89);

        // GAP_CYCLES=0 instance: no bubble between stages
        start2 = 1'b1; tick(); start2 = 1'b0;
        xf = 0; dc = 0; dy = -1;
        for (int k = 1; k <= 90; k++) begin
            if (valid2 && ready2) xf++;
            if (done2) begin dc++; dy = k; end
            if (k == 16) begin chk("g0_c16_even", d_even2, 30); chk("g0_c16_s", s2, 0); end
            if (k == 17) begin chk("g0_c17_valid", valid2, 1); chk("g0_c17_s", s2, 1);
                               chk("g0_c17_even", d_even2, 0); end
            tick();
        end
        chk("g0_xfers", xf, 80); chk("g0_dcnt", dc, 1); chk("g0_dcyc", dy, 81);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
